// File: rtl/btn_led_mmio_if.sv
// btn_led_mmio_if: picorv32 native memory bus slice seen by the button/LED block.
// The address decoder drives sel; mem_valid/mem_ready form the request/ack pair.
interface btn_led_mmio_if;
   logic        sel;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;

   modport master (
      output sel,
      output mem_valid,
      output mem_addr,
      output mem_wdata,
      output mem_wstrb,
      input  mem_ready,
      input  mem_rdata
   );

   modport slave (
      input  sel,
      input  mem_valid,
      input  mem_addr,
      input  mem_wdata,
      input  mem_wstrb,
      output mem_ready,
      output mem_rdata
   );
endinterface

// File: rtl/btn_led_mmio.sv
// btn_led_mmio: N-channel button/LED peripheral on the picorv32 native bus.
// Buttons go through a 2-flop synchroniser and a per-channel debouncer; stable
// edges latch sticky press/release events (write-1-to-clear) feeding a maskable
// level irq. LEDs come from a memory-mapped register.
// Optional macro BTN_LED_PWM_EN adds an 8-bit PWM duty register at 0x10 that
// dims all LEDs; without it 0x10 reads 0 and no PWM logic exists.
// Register map (mem_addr[4:2]): 0 LED, 1 BTN, 2 EVT, 3 IEN, 4 PWM, others read 0.
module btn_led_mmio #(
   parameter int               N_BTN           = 2,
   parameter int               N_LED           = 4,
   parameter int               DEBOUNCE_CYCLES = 500000,
   parameter logic [N_LED-1:0] LED_RESET       = '0
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [N_BTN-1:0] buttons_i,
   output logic [N_LED-1:0] led,
   output logic             irq,
   btn_led_mmio_if.slave    bus
);
   localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int             NE       = 2 * N_BTN;
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [N_BTN-1:0] sync_a;
   logic [N_BTN-1:0] sync_b;
   logic [N_BTN-1:0] stable;
   logic [N_BTN-1:0] chg;
   logic [CW-1:0]    cnt [N_BTN];

   logic [N_LED-1:0] led_reg;
   logic [NE-1:0]    evt;
   logic [NE-1:0]    ien;
   logic [NE-1:0]    ev_set;
   logic [NE-1:0]    ev_clr;

   logic             txn;
   logic             wr;
   logic [2:0]       idx;
   logic [31:0]      bm;
   logic [31:0]      rd_mux;
   logic             unused_addr;

`ifdef BTN_LED_PWM_EN
   logic [7:0]       pwm_cnt;
   logic [7:0]       duty;
   logic [7:0]       duty_act;
   logic [N_LED-1:0] led_q;
`endif

   assign txn         = bus.mem_valid & bus.sel & ~bus.mem_ready;
   assign wr          = txn & (|bus.mem_wstrb);
   assign idx         = bus.mem_addr[4:2];
   assign bm          = {{8{bus.mem_wstrb[3]}}, {8{bus.mem_wstrb[2]}},
                         {8{bus.mem_wstrb[1]}}, {8{bus.mem_wstrb[0]}}};
   assign unused_addr = ^{bus.mem_addr[31:5], bus.mem_addr[1:0]};

   // two-flop metastability guard on the raw button levels
   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= buttons_i;
         sync_b <= sync_a;
      end
   end

   // change pulse: synced level has differed from stable for the full window
   always_comb begin
      chg = '0;
      for (int i = 0; i < N_BTN; i++) begin
         chg[i] = (sync_b[i] != stable[i]) && (cnt[i] == CNT_LAST);
      end
   end

   // per-channel debounce counter, cleared whenever the input agrees with stable
   always_ff @(posedge clk) begin
      if (!resetn) begin
         stable <= '0;
         for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            if (sync_b[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (chg[i]) begin
               cnt[i]    <= '0;
               stable[i] <= sync_b[i];
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   // press events in the low half, release events in the high half
   assign ev_set = {chg & stable, chg & ~stable};
   assign ev_clr = (wr && idx == 3'd2) ? NE'(bus.mem_wdata & bm) : '0;

   // read data mux, zero-extended; unmapped offsets read 0
   always_comb begin
      rd_mux = '0;
      case (idx)
         3'd0: rd_mux[N_LED-1:0] = led_reg;
         3'd1: rd_mux[N_BTN-1:0] = stable;
         3'd2: rd_mux[NE-1:0]    = evt;
         3'd3: rd_mux[NE-1:0]    = ien;
`ifdef BTN_LED_PWM_EN
         3'd4: rd_mux[7:0]       = duty;
`endif
         default: ;
      endcase
   end

   // single-cycle acknowledge; rdata held at zero outside the ack cycle
   always_ff @(posedge clk) begin
      if (!resetn) begin
         bus.mem_ready <= 1'b0;
         bus.mem_rdata <= '0;
      end else begin
         bus.mem_ready <= txn;
         bus.mem_rdata <= txn ? rd_mux : '0;
      end
   end

   // LED / event / enable registers and registered irq; a new event beats a clear
   always_ff @(posedge clk) begin
      if (!resetn) begin
         led_reg <= LED_RESET;
         evt     <= '0;
         ien     <= '0;
         irq     <= 1'b0;
      end else begin
         irq <= |(evt & ien);
         evt <= (evt & ~ev_clr) | ev_set;
         if (wr && idx == 3'd0) begin
            led_reg <= (led_reg & ~N_LED'(bm)) | N_LED'(bus.mem_wdata & bm);
         end
         if (wr && idx == 3'd3) begin
            ien <= (ien & ~NE'(bm)) | NE'(bus.mem_wdata & bm);
         end
      end
   end

`ifdef BTN_LED_PWM_EN
   // free-running PWM; a new duty is adopted only at the 255->0 wrap
   always_ff @(posedge clk) begin
      if (!resetn) begin
         pwm_cnt  <= '0;
         duty     <= 8'hFF;
         duty_act <= 8'hFF;
         led_q    <= LED_RESET;
      end else begin
         pwm_cnt <= pwm_cnt + 8'd1;
         if (pwm_cnt == 8'hFF) duty_act <= duty;
         if (wr && idx == 3'd4) begin
            duty <= (duty & ~bm[7:0]) | (bus.mem_wdata[7:0] & bm[7:0]);
         end
         led_q <= led_reg & {N_LED{pwm_cnt < duty_act}};
      end
   end

   assign led = led_q;
`else
   assign led = led_reg;
`endif

endmodule
